// File: rtl/video_timing_pkg.sv
// Shared state type, default 1080p60 timing constants and colour-bar palette
// for the raster timing generator.
package video_timing_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } vt_state_e;

  localparam int unsigned DEF_H_ACTIVE    = 1920;
  localparam int unsigned DEF_H_FP        = 88;
  localparam int unsigned DEF_H_SYNC      = 44;
  localparam int unsigned DEF_H_BP        = 148;
  localparam int unsigned DEF_V_ACTIVE    = 1080;
  localparam int unsigned DEF_V_FP        = 4;
  localparam int unsigned DEF_V_SYNC      = 5;
  localparam int unsigned DEF_V_BP        = 36;
  localparam int unsigned DEF_LOCK_SETTLE = 1024;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_lock_qualifier.sv
// Reset-release and PLL-lock synchronisers plus the WAIT_LOCK/SETTLE/RUN
// qualification FSM that gates the raster.
module lock_qualifier
  import video_timing_pkg::*;
#(
  parameter int unsigned LOCK_SETTLE = DEF_LOCK_SETTLE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pll_locked_i,
  output logic rst_sync_no,
  output logic run_en_o,
  output logic running_o
);

  localparam int unsigned CNT_W = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;

  logic [1:0]       rst_sync_q;
  logic [1:0]       lock_sync_q;
  logic             lock_s;
  vt_state_e        state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d, settle_inc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_sync_no = rst_sync_q[1];

  // Lock synchroniser clears on the raw reset so it fills while reset release syncs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lock_sync_q <= '0;
    else         lock_sync_q <= {lock_sync_q[0], pll_locked_i};
  end

  assign lock_s = lock_sync_q[1];

  always_ff @(posedge clk_i or negedge rst_sync_no) begin
    if (!rst_sync_no) begin
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    settle_inc = settle_q + CNT_W'(1);
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else begin
          settle_d = settle_inc;
          if (settle_inc >= CNT_W'(LOCK_SETTLE - 1)) state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // A lock drop blanks the raster on the same edge the FSM leaves RUN.
  assign running_o = (state_q == RUN);
  assign run_en_o  = running_o && lock_s;

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters and registered sync/DE/coordinate decode for 1080p60-class
// video. Define VIDEO_TIMING_TESTPAT_EN to add the colour-bar rgb output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter logic        HSYNC_POL   = 1'b1,
  parameter logic        VSYNC_POL   = 1'b1,
  parameter int unsigned LOCK_SETTLE = DEF_LOCK_SETTLE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] pix_x,
  output logic [10:0] pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
`ifdef VIDEO_TIMING_TESTPAT_EN
  ,
  output logic [23:0] rgb
`endif
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic        rst_sync_n, run_en;
  logic [11:0] h_q, h_d, pix_x_q, pix_x_d;
  logic [10:0] v_q, v_d, pix_y_q, pix_y_d;
  logic        h_act, v_act;
  logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic        line_start_q, line_start_d, frame_start_q, frame_start_d;

  lock_qualifier #(
    .LOCK_SETTLE(LOCK_SETTLE)
  ) u_lock_qualifier (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pll_locked_i(pll_locked),
    .rst_sync_no (rst_sync_n),
    .run_en_o    (run_en),
    .running_o   (running)
  );

  // Counters sit at (0,0) whenever the raster is not enabled.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_en) begin
      if (h_q == 12'(H_TOTAL - 1)) begin
        v_d = (v_q == 11'(V_TOTAL - 1)) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 12'd1;
        v_d = v_q;
      end
    end
  end

  always_comb begin
    h_act         = (h_q < 12'(H_ACTIVE));
    v_act         = (v_q < 11'(V_ACTIVE));
    de_d          = run_en && h_act && v_act;
    hsync_d       = (run_en && h_q >= 12'(HS_START) && h_q < 12'(HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (run_en && v_q >= 11'(VS_START) && v_q < 11'(VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    pix_x_d       = de_d ? h_q : '0;
    pix_y_d       = de_d ? v_q : '0;
    line_start_d  = run_en && (h_q == '0) && v_act;
    frame_start_d = run_en && (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      h_q           <= '0;
      v_q           <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VIDEO_TIMING_TESTPAT_EN
  localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [11:0] bar_idx;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    bar_idx = h_q / 12'(BAR_W);
    rgb_d   = de_d ? bar_colour((bar_idx > 12'd7) ? 3'd7 : bar_idx[2:0]) : '0;
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) rgb_q <= '0;
    else             rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen with small raster parameters and
// randomized PLL-lock / reset stimulus.
module tb_video_timing_gen;

`ifdef VIDEO_TIMING_TESTPAT_EN
  localparam int H_ACT = 16;
`else
  localparam int H_ACT = 8;
`endif
  localparam int H_FPW = 2, H_SW = 2, H_BPW = 2;
  localparam int V_ACT = 4, V_FPW = 1, V_SW = 1, V_BPW = 1;
  localparam int H_TOT = H_ACT + H_FPW + H_SW + H_BPW;
  localparam int V_TOT = V_ACT + V_FPW + V_SW + V_BPW;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int LS    = 4;
  localparam logic HSP = 1'b1;
  localparam logic VSP = 1'b1;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
    logic        run;
    logic [23:0] rgb;
  } obs_t;

  logic        clk, rst_n, pll_locked;
  logic        hsync, vsync, de, line_start, frame_start, running;
  logic [11:0] pix_x;
  logic [10:0] pix_y;
`ifdef VIDEO_TIMING_TESTPAT_EN
  logic [23:0] rgb;
`endif

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];

  video_timing_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FPW), .H_SYNC(H_SW), .H_BP(H_BPW),
    .V_ACTIVE(V_ACT), .V_FP(V_FPW), .V_SYNC(V_SW), .V_BP(V_BPW),
    .HSYNC_POL(HSP), .VSYNC_POL(VSP), .LOCK_SETTLE(LS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
`ifdef VIDEO_TIMING_TESTPAT_EN
    , .rgb(rgb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: once the synchronised lock has been continuously high for more
  // than LS clocks, the raster position is simply the elapsed clock count.
  function automatic obs_t expect_from(input int streak);
    obs_t e;
    int p, h, v;
    e     = '0;
    e.hs  = ~HSP;
    e.vs  = ~VSP;
    e.run = (streak >= LS);
    if (streak >= LS + 1) begin
      p = streak - LS - 1;
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      e.de = (h < H_ACT) && (v < V_ACT);
      e.hs = (h >= H_ACT + H_FPW && h < H_ACT + H_FPW + H_SW) ? HSP : ~HSP;
      e.vs = (v >= V_ACT + V_FPW && v < V_ACT + V_FPW + V_SW) ? VSP : ~VSP;
      e.x  = e.de ? 12'(h) : '0;
      e.y  = e.de ? 11'(v) : '0;
      e.ls = (h == 0) && (v < V_ACT);
      e.fs = (h == 0) && (v == 0);
`ifdef VIDEO_TIMING_TESTPAT_EN
      e.rgb = e.de ? BARS[h / (H_ACT / 8)] : '0;
`endif
    end
    return e;
  endfunction

  function automatic obs_t sample_dut();
    obs_t a;
    a     = '0;
    a.hs  = hsync;
    a.vs  = vsync;
    a.de  = de;
    a.x   = pix_x;
    a.y   = pix_y;
    a.ls  = line_start;
    a.fs  = frame_start;
    a.run = running;
`ifdef VIDEO_TIMING_TESTPAT_EN
    a.rgb = rgb;
`endif
    return a;
  endfunction

  int m_ls1 = 0, m_ls2 = 0, m_streak = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ls1 = 0; m_ls2 = 0; m_streak = 0;
      exp_q.push_back(expect_from(0));
    end else begin
      exp_q.push_back(expect_from(m_streak));
      m_ls2    = m_ls1;
      m_ls1    = int'(pll_locked);
      m_streak = (m_ls2 != 0) ? m_streak + 1 : 0;
    end
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample_dut();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b rgb=%h need hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b rgb=%h",
                 $time, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, a.run, a.rgb,
                 e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.run, e.rgb);
      end
    end
  end

  task automatic check_int(input string name, input int got, input int need);
    total++;
    if (got != need) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d", name, got, need);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic wait_running(input logic lvl, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (running === lvl) begin n = i; break; end
    end
  endtask

  task automatic wait_pixel(input int px, input int py, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (de === 1'b1 && pix_x == 12'(px) && pix_y == 11'(py)) begin n = i; break; end
    end
  endtask

  initial begin
    int n, de_cnt, hs_cnt, vs_cnt;
    obs_t a, r;
    rst_n = 1'b0;
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;

    // Power-up: sync delay plus settle, then (0,0) on the next output cycle.
    wait_running(1'b1, 40, n);
    check_int("reset_to_running", n, 2 + LS);
    @(negedge clk);
    check_int("first_frame_start", int'(frame_start), 1);
    check_int("first_de", int'(de), 1);

    // One full frame: activity counts and frame_start period.
    n = -1; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 1; i <= FRAME + 5; i++) begin
      if (de === 1'b1) de_cnt++;
      if (hsync === HSP) hs_cnt++;
      if (vsync === VSP) vs_cnt++;
      @(negedge clk);
      if (frame_start === 1'b1) begin n = i; break; end
    end
    check_int("frame_period", n, FRAME);
    check_int("de_per_frame", de_cnt, H_ACT * V_ACT);
    check_int("hsync_per_frame", hs_cnt, H_SW * V_TOT);
    check_int("vsync_per_frame", vs_cnt, V_SW * H_TOT);

    // Lock lost mid line 2, then relock.
    wait_pixel(3, 2, 2 * FRAME, n);
    check_range("find_line2", n, 1, 2 * FRAME);
    #2 pll_locked = 1'b0;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (running === 1'b0 && de === 1'b0 && hsync === ~HSP && vsync === ~VSP) begin n = i; break; end
    end
    check_range("drop_blank_latency", n, 1, 3);
    repeat (5) @(negedge clk);
    #2 pll_locked = 1'b1;
    wait_running(1'b1, 40, n);
    check_int("relock_to_running", n, 2 + LS);
    @(negedge clk);
    check_int("relock_frame_start", int'(frame_start), 1);

    // Low pulse inside SETTLE restarts the settle count.
    @(negedge clk);
    #2 pll_locked = 1'b0;
    repeat (8) @(negedge clk);
    #2 pll_locked = 1'b1;
    repeat (2) @(negedge clk);
    #2 pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    #2 pll_locked = 1'b1;
    wait_running(1'b1, 40, n);
    check_int("settle_restart", n, 2 + LS);

    // Asynchronous reset mid-frame must act without a clock edge.
    wait_pixel(5, 1, 2 * FRAME, n);
    check_range("find_line1", n, 1, 2 * FRAME);
    #2 rst_n = 1'b0;
    #1;
    a = sample_dut();
    r = expect_from(0);
    total++;
    if (a !== r) begin
      bad++;
      $display("FAIL async_reset got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b need reset values",
               a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, a.run);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_running(1'b1, 40, n);
    check_int("post_reset_running", n, 2 + LS);

    // Randomized lock outages and short resets, checked by the scoreboard.
    for (int seg = 0; seg < 16; seg++) begin
      repeat ($urandom_range(10, 3 * FRAME)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        #($urandom_range(1, 4)) rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #($urandom_range(1, 4)) rst_n = 1'b1;
      end else begin
        #($urandom_range(1, 4)) pll_locked = 1'b0;
        repeat ($urandom_range(1, 10)) @(negedge clk);
        #($urandom_range(1, 4)) pll_locked = 1'b1;
      end
    end
    repeat (2 * FRAME) @(negedge clk);
    @(negedge clk);
    check_range("scoreboard_drain", exp_q.size(), 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish got=timeout need=finish");
    $fatal(1, "watchdog");
  end

endmodule
